led_gpio_ctrl: RTL and testbench
================================

Name: led_gpio_ctrl

Overview:
- Memory-mapped LED/GPIO output controller on the Ibex data bus; replaces the ad-hoc LED capture register in the FPGA top level.
- Provides NumLeds outputs with four write styles (direct, set, clear, toggle) and a per-LED hardware blink mode driven by a programmable prescaler.
- Sits behind the top-level address decoder, alongside the SRAM. It sees only requests already routed to it.

Parameters:
- NumLeds, 4, number of LED outputs (1..32).
- DivWidth, 24, width of the blink prescaler register and counter (1..32).

Ports:
- clk_sys  in  1  system clock
- rst_sys_n  in  1  asynchronous active-low reset
- req_i  in  1  bus request, already decoded for this block
- gnt_o  out  1  grant
- we_i  in  1  write enable
- be_i  in  4  byte enables
- addr_i  in  32  byte address; only addr_i[4:2] are used
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid
- rdata_o  out  32  read data
- err_o  out  1  response error, qualified by rvalid_o
- led_o  out  NumLeds  LED drive, registered

Behaviour:
- Reset value of every output and state element: rvalid_o=0, rdata_o=0, err_o=0, led_o=0, OUT=0, BLINK_EN=0, BLINK_DIV=0, cnt=0, phase=1. gnt_o follows req_i, so it is 0 whenever req_i is 0.
- Handshake:
  - gnt_o = req_i, combinational; every request is accepted in the cycle it is asserted.
  - rvalid_o pulses exactly one cycle after each accepted request, for reads and writes alike. Back-to-back requests give back-to-back rvalid.
  - rdata_o and err_o are valid only while rvalid_o=1. Otherwise rdata_o=0 and err_o=0.
- Register map (word offset addr_i[4:2]):
  - 0x00 OUT: read/write, current output value.
  - 0x04 SET: write-only; OUT |= data.
  - 0x08 CLR: write-only; OUT &= ~data.
  - 0x0C TGL: write-only; OUT ^= data.
  - 0x10 BLINK_EN: read/write, per-LED blink enable.
  - 0x14 BLINK_DIV: read/write, DivWidth bits.
  - 0x18 ID: read-only; reads {16'h1ED0, 8'd0, NumLeds[7:0]}.
  - 0x1C: unmapped.
- Byte enables:
  - Write data is masked per byte: bits in bytes with be_i[k]=0 are treated as 0 for SET/CLR/TGL.
  - For OUT, BLINK_EN and BLINK_DIV, those bits keep their old value.
  - Reads always return the full word regardless of be_i.
- Width rules:
  - Bits at or above NumLeds (or DivWidth for BLINK_DIV) ignore writes and read as 0.
  - Reads of SET/CLR/TGL return 0 with err_o=0.
- Errors: err_o=1 with rvalid_o for any access to 0x1C and for a write to ID. Such accesses change no state, and rdata_o=0.
- Register update timing: a write updates the register at the clock edge that accepts it. The new value is visible on led_o one cycle later.
- Blink prescaler:
  - If BLINK_DIV=0: cnt holds at 0 and phase holds at 1, so blinking LEDs are steady on.
  - Otherwise cnt increments each cycle. When cnt==BLINK_DIV: cnt wraps to 0 and phase toggles. The phase period is therefore BLINK_DIV+1 cycles.
  - A write to BLINK_DIV (any byte enable set) clears cnt to 0 in the same edge; phase is unchanged.
  - If BLINK_DIV is written to a value below the current cnt, the clear prevents a long wrap.
- Output: led_o[i] <= OUT[i] & (~BLINK_EN[i] | phase), registered every cycle.
- Simultaneous events: a phase toggle and a register write in the same cycle both take effect. led_o the next cycle reflects the new OUT/BLINK_EN and the new phase.
- Reset mid-transaction: asynchronous assertion clears all state immediately. A pending rvalid is dropped, and the master must also be reset.

Test Plan:
- Reset, then read ID at offset 0x18 with NumLeds=4 -> rvalid next cycle, rdata=32'h1ED0_0004, err=0; led_o=0.
- Write OUT=0xA, then SET 0x1, then CLR 0x8, then TGL 0x6 -> OUT reads 0xA, then 0xB, then 0x3, then 0x5; led_o tracks each value one cycle after each write.
- Write OUT=0xFFFFFFFF with be=4'b0000, then with be=4'b0001 -> OUT stays 0x0, then becomes 0xF; upper bits read 0.
- OUT=0xF, BLINK_EN=0x3, BLINK_DIV=4 -> led_o[1:0] toggle every 5 cycles (period 10), led_o[3:2] steady 1; writing BLINK_DIV=0 -> led_o=0xF steady.
- Access offset 0x1C (read), then write ID -> both give rvalid=1, err=1, rdata=0; ID reread unchanged.
- Back-to-back read, write, read on consecutive cycles -> three consecutive rvalid pulses with correct data order; assert rst_sys_n low mid-stream -> rvalid_o=0, led_o=0 immediately.

Source files
------------

// File: rtl/led_gpio_ctrl.sv
// LED/GPIO output controller on the Ibex data bus.
// Word registers (byte offset): 0x00 OUT, 0x04 SET, 0x08 CLR, 0x0C TGL,
// 0x10 BLINK_EN, 0x14 BLINK_DIV, 0x18 ID (read-only), 0x1C unmapped (error).
// Blinking LEDs are gated by a phase bit. The phase toggles every BLINK_DIV+1
// cycles. When BLINK_DIV is 0 the phase is held at 1, so blinking LEDs stay on.
//
// Ports:
//   clk_sys, rst_sys_n : clock, asynchronous active-low reset
//   req_i, gnt_o       : request and grant (grant is combinational, always given)
//   we_i, be_i         : write enable and byte enables
//   addr_i, wdata_i    : byte address (only [4:2] decoded) and write data
//   rvalid_o           : one-cycle response pulse per accepted request
//   rdata_o, err_o     : response data and error, zero unless rvalid_o is high
//   led_o              : registered LED drive
module led_gpio_ctrl #(
    parameter int unsigned NumLeds  = 4,
    parameter int unsigned DivWidth = 24
) (
    input  logic                clk_sys,
    input  logic                rst_sys_n,
    input  logic                req_i,
    output logic                gnt_o,
    input  logic                we_i,
    input  logic [3:0]          be_i,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         wdata_i,
    output logic                rvalid_o,
    output logic [31:0]         rdata_o,
    output logic                err_o,
    output logic [NumLeds-1:0]  led_o
);

    localparam logic [2:0]  OffOut   = 3'd0;
    localparam logic [2:0]  OffSet   = 3'd1;
    localparam logic [2:0]  OffClr   = 3'd2;
    localparam logic [2:0]  OffTgl   = 3'd3;
    localparam logic [2:0]  OffBlink = 3'd4;
    localparam logic [2:0]  OffDiv   = 3'd5;
    localparam logic [2:0]  OffId    = 3'd6;
    localparam logic [2:0]  OffRsvd  = 3'd7;
    localparam logic [31:0] IdValue  = {16'h1ED0, 8'h00, 8'(NumLeds)};

    logic [NumLeds-1:0]  out_q, out_d, blink_q, blink_d;
    logic [DivWidth-1:0] div_q, div_d, cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic [31:0]         bmask, wdata_m, rdata_d;
    logic [2:0]          off;
    logic                wr_en, rd_en, acc_err, div_wr;
    logic                unused_bits;

    assign gnt_o   = req_i;
    assign off     = addr_i[4:2];
    assign bmask   = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
    assign wdata_m = wdata_i & bmask;
    assign acc_err = req_i & ((off == OffRsvd) | ((off == OffId) & we_i));
    assign wr_en   = req_i & we_i & ~acc_err;
    assign rd_en   = req_i & ~we_i & ~acc_err;
    assign div_wr  = wr_en & (off == OffDiv) & (|be_i);

    // Address bits outside [4:2] and write data above the register widths are ignored.
    assign unused_bits = ^{addr_i[31:5], addr_i[1:0], wdata_m};

    // Register write decode; disabled bytes keep old bits on OUT/BLINK_EN/BLINK_DIV.
    always_comb begin
        out_d   = out_q;
        blink_d = blink_q;
        div_d   = div_q;
        if (wr_en) begin
            case (off)
                OffOut:   out_d   = (out_q & ~bmask[NumLeds-1:0]) | wdata_m[NumLeds-1:0];
                OffSet:   out_d   = out_q | wdata_m[NumLeds-1:0];
                OffClr:   out_d   = out_q & ~wdata_m[NumLeds-1:0];
                OffTgl:   out_d   = out_q ^ wdata_m[NumLeds-1:0];
                OffBlink: blink_d = (blink_q & ~bmask[NumLeds-1:0]) | wdata_m[NumLeds-1:0];
                OffDiv:   div_d   = (div_q & ~bmask[DivWidth-1:0]) | wdata_m[DivWidth-1:0];
                default:  ;
            endcase
        end
    end

    // Read mux; writes and errored accesses return zero.
    always_comb begin
        rdata_d = 32'd0;
        if (rd_en) begin
            case (off)
                OffOut:   rdata_d = 32'(out_q);
                OffBlink: rdata_d = 32'(blink_q);
                OffDiv:   rdata_d = 32'(div_q);
                OffId:    rdata_d = IdValue;
                default:  rdata_d = 32'd0;
            endcase
        end
    end

    // Blink prescaler; a BLINK_DIV write restarts the count so a smaller divisor
    // never has to wait for a full counter wrap.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (div_wr) begin
            cnt_d = '0;
        end else if (div_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == div_q) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + DivWidth'(1);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            out_q    <= '0;
            blink_q  <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b1;
            led_o    <= '0;
            rvalid_o <= 1'b0;
            rdata_o  <= 32'd0;
            err_o    <= 1'b0;
        end else begin
            out_q    <= out_d;
            blink_q  <= blink_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            led_o    <= out_q & (~blink_q | {NumLeds{phase_q}});
            rvalid_o <= req_i;
            rdata_o  <= rdata_d;
            err_o    <= acc_err;
        end
    end

endmodule

// File: tb/tb_led_gpio_ctrl.sv
// Self-checking bench for led_gpio_ctrl: directed scenarios plus random bus
// traffic, compared cycle by cycle against a behavioural register model.
module tb_led_gpio_ctrl;

    localparam int unsigned NL = 4;
    localparam int unsigned DW = 24;
    localparam logic [31:0] LED_MASK = 32'h0000_000F;
    localparam logic [31:0] DIV_MASK = 32'h00FF_FFFF;
    localparam logic [31:0] ID_VAL   = 32'h1ED0_0004;

    logic          clk_sys = 1'b0;
    logic          rst_sys_n;
    logic          req_i, gnt_o, we_i;
    logic [3:0]    be_i;
    logic [31:0]   addr_i, wdata_i, rdata_o;
    logic          rvalid_o, err_o;
    logic [NL-1:0] led_o;

    int errors = 0;
    int checks = 0;

    // Behavioural model state.
    logic [31:0] m_out, m_blink, m_div;
    int unsigned m_cnt;
    logic        m_phase;

    always #5 clk_sys = ~clk_sys;

    led_gpio_ctrl #(.NumLeds(NL), .DivWidth(DW)) dut (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .req_i     (req_i),
        .gnt_o     (gnt_o),
        .we_i      (we_i),
        .be_i      (be_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .rvalid_o  (rvalid_o),
        .rdata_o   (rdata_o),
        .err_o     (err_o),
        .led_o     (led_o)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
        return m;
    endfunction

    task automatic model_reset();
        m_out = 0; m_blink = 0; m_div = 0; m_cnt = 0; m_phase = 1'b1;
    endtask

    // One bus cycle: drive at the falling edge, predict, clock, check at the next falling edge.
    task automatic xfer(input logic req, input logic we, input logic [3:0] be,
                        input logic [2:0] off, input logic [31:0] wd);
        logic [31:0] bm, wm, exp_rd, exp_led;
        logic        exp_err, chk_rd;
        req_i   = req;
        we_i    = we;
        be_i    = be;
        addr_i  = {27'($urandom), off, 2'($urandom)};
        wdata_i = wd;
        #1;
        check("gnt", 32'(gnt_o), 32'(req));

        bm      = byte_mask(be);
        wm      = wd & bm;
        exp_err = req && (off == 3'd7 || (off == 3'd6 && we));
        exp_rd  = 0;
        if (req && !we && !exp_err) begin
            case (off)
                3'd0: exp_rd = m_out;
                3'd4: exp_rd = m_blink;
                3'd5: exp_rd = m_div;
                3'd6: exp_rd = ID_VAL;
                default: exp_rd = 0;
            endcase
        end
        chk_rd  = !(req && we && !exp_err);
        exp_led = m_out & (~m_blink | (m_phase ? 32'hFFFF_FFFF : 32'h0)) & LED_MASK;

        // Prescaler advances on the old divisor; a divisor write only restarts the count.
        if (req && we && off == 3'd5 && be != 4'b0) m_cnt = 0;
        else if (m_div == 0) begin m_cnt = 0; m_phase = 1'b1; end
        else if (m_cnt == m_div) begin m_cnt = 0; m_phase = ~m_phase; end
        else m_cnt = m_cnt + 1;

        if (req && we && !exp_err) begin
            case (off)
                3'd0: m_out   = ((m_out & ~bm) | wm) & LED_MASK;
                3'd1: m_out   = (m_out | wm) & LED_MASK;
                3'd2: m_out   = m_out & ~wm;
                3'd3: m_out   = (m_out ^ wm) & LED_MASK;
                3'd4: m_blink = ((m_blink & ~bm) | wm) & LED_MASK;
                3'd5: m_div   = ((m_div & ~bm) | wm) & DIV_MASK;
                default: ;
            endcase
        end

        @(posedge clk_sys);
        @(negedge clk_sys);
        check("rvalid", 32'(rvalid_o), 32'(req));
        check("err", 32'(err_o), 32'(exp_err));
        if (chk_rd) check("rdata", rdata_o, exp_rd);
        check("led", 32'(led_o), exp_led);
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] wd);
        xfer(1'b1, 1'b1, 4'hF, off, wd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) xfer(1'b0, 1'b0, 4'h0, 3'd0, 32'd0);
    endtask

    // Read with an additional check against a literal expected value.
    task automatic rd_expect(input string tag, input logic [2:0] off, input logic [31:0] exp);
        xfer(1'b1, 1'b0, 4'hF, off, 32'd0);
        check(tag, rdata_o, exp);
    endtask

    initial begin
        int last_chg, nchg;
        logic prev;

        rst_sys_n = 1'b0;
        req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = 0; wdata_i = 0;
        model_reset();
        #12;
        check("rst_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_led", 32'(led_o), 32'd0);
        check("rst_gnt", 32'(gnt_o), 32'd0);
        @(negedge clk_sys);
        rst_sys_n = 1'b1;
        @(negedge clk_sys);

        rd_expect("id", 3'd6, 32'h1ED0_0004);

        // Write styles.
        wr(3'd0, 32'hA); rd_expect("out_a", 3'd0, 32'hA);
        wr(3'd1, 32'h1); rd_expect("out_set", 3'd0, 32'hB);
        wr(3'd2, 32'h8); rd_expect("out_clr", 3'd0, 32'h3);
        wr(3'd3, 32'h6); rd_expect("out_tgl", 3'd0, 32'h5);
        check("led_tgl", 32'(led_o), 32'h5);

        // Byte enables and width masking.
        wr(3'd0, 32'h0);
        xfer(1'b1, 1'b1, 4'b0000, 3'd0, 32'hFFFF_FFFF);
        rd_expect("be_none", 3'd0, 32'h0);
        xfer(1'b1, 1'b1, 4'b0001, 3'd0, 32'hFFFF_FFFF);
        rd_expect("be_low", 3'd0, 32'hF);
        xfer(1'b1, 1'b1, 4'b0010, 3'd5, 32'h0000_0300);
        rd_expect("div_be", 3'd5, 32'h0000_0300);

        // Blink: LEDs 1:0 toggle every 5 cycles, 3:2 steady on.
        wr(3'd0, 32'hF); wr(3'd4, 32'h3); wr(3'd5, 32'd4);
        nchg = 0; last_chg = -1; prev = led_o[0];
        for (int i = 0; i < 32; i++) begin
            idle(1);
            check("blink_hi", 32'(led_o[3:2]), 32'h3);
            if (led_o[0] !== prev) begin
                if (last_chg >= 0) check("blink_gap", 32'(i - last_chg), 32'd5);
                last_chg = i; nchg++;
            end
            prev = led_o[0];
        end
        check("blink_nchg_ge6", 32'(nchg >= 6), 32'd1);
        wr(3'd5, 32'd0);
        idle(3);
        for (int i = 0; i < 6; i++) begin
            idle(1);
            check("div0_steady", 32'(led_o), 32'hF);
        end

        // Error accesses.
        xfer(1'b1, 1'b0, 4'hF, 3'd7, 32'd0);
        check("rsvd_err", 32'(err_o), 32'd1);
        check("rsvd_rdata", rdata_o, 32'd0);
        xfer(1'b1, 1'b1, 4'hF, 3'd6, 32'h1234_5678);
        check("idwr_err", 32'(err_o), 32'd1);
        rd_expect("id_again", 3'd6, ID_VAL);
        rd_expect("setreg_rd", 3'd1, 32'd0);

        // Back-to-back read, write, read.
        rd_expect("b2b_r0", 3'd0, 32'hF);
        wr(3'd0, 32'h6);
        rd_expect("b2b_r1", 3'd0, 32'h6);

        // Random traffic; small divisors so the phase moves.
        for (int i = 0; i < 600; i++) begin
            logic [2:0]  off;
            logic        we;
            logic [31:0] wd;
            off = 3'($urandom);
            we  = 1'($urandom);
            wd  = (off == 3'd5) ? 32'($urandom_range(0, 7)) : $urandom;
            xfer(($urandom_range(0, 3) != 0), we, 4'($urandom), off, wd);
        end

        // Reset while a response is in flight.
        wr(3'd4, 32'h0);
        wr(3'd0, 32'hF);
        req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h0;
        @(posedge clk_sys);
        #1;
        check("pre_rst_rvalid", 32'(rvalid_o), 32'd1);
        check("pre_rst_led", 32'(led_o), 32'hF);
        req_i = 1'b0;
        rst_sys_n = 1'b0;
        #1;
        check("mid_rst_rvalid", 32'(rvalid_o), 32'd0);
        check("mid_rst_led", 32'(led_o), 32'd0);
        check("mid_rst_rdata", rdata_o, 32'd0);
        @(negedge clk_sys);
        rst_sys_n = 1'b1;
        model_reset();
        @(negedge clk_sys);
        rd_expect("post_rst_out", 3'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
